// File: rtl/otg_hpi_sequencer.sv
// otg_hpi_sequencer
// Drives the CY7C67200 Host Port Interface pins for one 16-bit register
// read or write at a time, with programmable setup, strobe, hold and
// recovery phases. It also synchronises the chip's interrupt line into clk.

module otg_hpi_sequencer #(
   parameter int SETUP_CYC    = 2,
   parameter int STROBE_CYC   = 6,
   parameter int HOLD_CYC     = 2,
   parameter int RECOVERY_CYC = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [1:0]  cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        busy,
   output logic [1:0]  otg_addr,
   output logic        otg_cs_n,
   output logic        otg_rd_n,
   output logic        otg_wr_n,
   output logic [15:0] otg_data_out,
   output logic        otg_data_oe,
   input  logic [15:0] otg_data_in,
   input  logic        otg_int,
   output logic        irq
);

   // A phase length of zero would mean "skip the phase", which the chip
   // cannot tolerate, so every phase lasts at least one cycle.
   localparam int S_EFF = (SETUP_CYC    < 1) ? 1 : SETUP_CYC;
   localparam int T_EFF = (STROBE_CYC   < 1) ? 1 : STROBE_CYC;
   localparam int H_EFF = (HOLD_CYC     < 1) ? 1 : HOLD_CYC;
   localparam int R_EFF = (RECOVERY_CYC < 1) ? 1 : RECOVERY_CYC;

   localparam int MAX_ST  = (S_EFF > T_EFF) ? S_EFF : T_EFF;
   localparam int MAX_HR  = (H_EFF > R_EFF) ? H_EFF : R_EFF;
   localparam int MAX_CYC = (MAX_ST > MAX_HR) ? MAX_ST : MAX_HR;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] S_LOAD = CNT_W'(S_EFF - 1);
   localparam logic [CNT_W-1:0] T_LOAD = CNT_W'(T_EFF - 1);
   localparam logic [CNT_W-1:0] H_LOAD = CNT_W'(H_EFF - 1);
   localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(R_EFF - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_RECOVER
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             write_q, write_d;
   logic             ready_d, busy_d, cs_n_d, rd_n_d, wr_n_d, oe_d, rsp_valid_d;
   logic [1:0]       addr_d;
   logic [15:0]      dout_d, rdata_d;
   logic             int_meta;

   // Next-state and next-output logic; every pin holds its value unless a
   // phase transition explicitly changes it, so all outputs stay registered.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      ready_d     = cmd_ready;
      busy_d      = busy;
      addr_d      = otg_addr;
      cs_n_d      = otg_cs_n;
      rd_n_d      = otg_rd_n;
      wr_n_d      = otg_wr_n;
      dout_d      = otg_data_out;
      oe_d        = otg_data_oe;
      rsp_valid_d = 1'b0;
      rdata_d     = rsp_rdata;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_d = ST_SETUP;
               cnt_d   = S_LOAD;
               write_d = cmd_write;
               addr_d  = cmd_addr;
               cs_n_d  = 1'b0;
               oe_d    = cmd_write;
               dout_d  = cmd_wdata;
               busy_d  = 1'b1;
               ready_d = 1'b0;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_STROBE;
               cnt_d   = T_LOAD;
               rd_n_d  = write_q;
               wr_n_d  = !write_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
               cnt_d   = H_LOAD;
               rd_n_d  = 1'b1;
               wr_n_d  = 1'b1;
               if (!write_q) begin
                  rdata_d = otg_data_in;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d     = ST_RECOVER;
               cnt_d       = R_LOAD;
               cs_n_d      = 1'b1;
               oe_d        = 1'b0;
               rsp_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RECOVER: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, phase counter and all HPI-facing outputs; reset drops any
   // transaction in flight and parks the bus idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         write_q      <= 1'b0;
         cmd_ready    <= 1'b1;
         busy         <= 1'b0;
         otg_addr     <= 2'd0;
         otg_cs_n     <= 1'b1;
         otg_rd_n     <= 1'b1;
         otg_wr_n     <= 1'b1;
         otg_data_out <= 16'd0;
         otg_data_oe  <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= 16'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         cmd_ready    <= ready_d;
         busy         <= busy_d;
         otg_addr     <= addr_d;
         otg_cs_n     <= cs_n_d;
         otg_rd_n     <= rd_n_d;
         otg_wr_n     <= wr_n_d;
         otg_data_out <= dout_d;
         otg_data_oe  <= oe_d;
         rsp_valid    <= rsp_valid_d;
         rsp_rdata    <= rdata_d;
      end
   end

   // Two-flop synchroniser for the asynchronous interrupt line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         int_meta <= 1'b0;
         irq      <= 1'b0;
      end else begin
         int_meta <= otg_int;
         irq      <= int_meta;
      end
   end

endmodule

// File: tb/tb_otg_hpi_sequencer.sv
// tb_otg_hpi_sequencer
// Drives directed and random HPI commands into a default-timed sequencer and
// a minimum-timed one, predicting every pin cycle by cycle from the phase
// lengths, and checks the interrupt synchroniser latency.

module tb_otg_hpi_sequencer;

   localparam int A_S = 2, A_T = 6, A_H = 2, A_R = 4;
   localparam int B_S = 0, B_T = 1, B_H = 0, B_R = 1;

   logic        clk, reset_n, sel;
   logic        cmd_valid, cmd_write, otg_int;
   logic [1:0]  cmd_addr;
   logic [15:0] cmd_wdata, otg_data_in;

   logic        a_valid, a_ready, a_rsp_valid, a_busy, a_cs_n, a_rd_n, a_wr_n, a_oe, a_irq;
   logic [1:0]  a_addr;
   logic [15:0] a_rdata, a_dout;
   logic        b_valid, b_ready, b_rsp_valid, b_busy, b_cs_n, b_rd_n, b_wr_n, b_oe, b_irq;
   logic [1:0]  b_addr;
   logic [15:0] b_rdata, b_dout;

   logic        o_ready, o_rsp_valid, o_busy, o_cs_n, o_rd_n, o_wr_n, o_oe;
   logic [1:0]  o_addr;
   logic [15:0] o_rdata, o_dout;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [15:0] mdl_rdata;

   assign a_valid     = cmd_valid & ~sel;
   assign b_valid     = cmd_valid & sel;
   assign o_ready     = sel ? b_ready     : a_ready;
   assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign o_busy      = sel ? b_busy      : a_busy;
   assign o_cs_n      = sel ? b_cs_n      : a_cs_n;
   assign o_rd_n      = sel ? b_rd_n      : a_rd_n;
   assign o_wr_n      = sel ? b_wr_n      : a_wr_n;
   assign o_oe        = sel ? b_oe        : a_oe;
   assign o_addr      = sel ? b_addr      : a_addr;
   assign o_rdata     = sel ? b_rdata     : a_rdata;
   assign o_dout      = sel ? b_dout      : a_dout;

   otg_hpi_sequencer dut_a (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .busy(a_busy),
      .otg_addr(a_addr), .otg_cs_n(a_cs_n), .otg_rd_n(a_rd_n), .otg_wr_n(a_wr_n),
      .otg_data_out(a_dout), .otg_data_oe(a_oe), .otg_data_in(otg_data_in),
      .otg_int(otg_int), .irq(a_irq)
   );

   otg_hpi_sequencer #(
      .SETUP_CYC(B_S), .STROBE_CYC(B_T), .HOLD_CYC(B_H), .RECOVERY_CYC(B_R)
   ) dut_b (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .busy(b_busy),
      .otg_addr(b_addr), .otg_cs_n(b_cs_n), .otg_rd_n(b_rd_n), .otg_wr_n(b_wr_n),
      .otg_data_out(b_dout), .otg_data_oe(b_oe), .otg_data_in(otg_data_in),
      .otg_int(otg_int), .irq(b_irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int eff(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, " ready"},     16'(o_ready),     16'd1);
      checkOutput({tag, " busy"},      16'(o_busy),      16'd0);
      checkOutput({tag, " cs_n"},      16'(o_cs_n),      16'd1);
      checkOutput({tag, " rd_n"},      16'(o_rd_n),      16'd1);
      checkOutput({tag, " wr_n"},      16'(o_wr_n),      16'd1);
      checkOutput({tag, " oe"},        16'(o_oe),        16'd0);
      checkOutput({tag, " rsp_valid"}, 16'(o_rsp_valid), 16'd0);
   endtask

   // Called at a negedge: presents a command and waits for the accepting edge.
   task automatic applyStimulus(input bit w, input logic [1:0] a, input logic [15:0] d);
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      checkOutput("ready before accept", 16'(o_ready), 16'd1);
      checkOutput("busy before accept",  16'(o_busy),  16'd0);
      @(posedge clk);
   endtask

   // Walks one transaction from the cycle after acceptance up to the first
   // cmd_ready cycle, predicting every pin from the phase lengths.
   task automatic runTxn(input bit w, input logic [1:0] a, input logic [15:0] d,
                         input logic [15:0] rv, input bit has_next, input bit nw,
                         input logic [1:0] na, input logic [15:0] nd);
      int s, t, h, r, total;
      bit in_txn, strobe;
      s = sel ? eff(B_S) : eff(A_S);
      t = sel ? eff(B_T) : eff(A_T);
      h = sel ? eff(B_H) : eff(A_H);
      r = sel ? eff(B_R) : eff(A_R);
      total = s + t + h + r + 1;
      for (int k = 1; k <= total; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (has_next) begin
               cmd_write = nw;
               cmd_addr  = na;
               cmd_wdata = nd;
            end else begin
               cmd_valid = 1'b0;
               cmd_write = 1'($urandom_range(0, 1));
               cmd_addr  = 2'($urandom);
               cmd_wdata = 16'($urandom);
            end
         end
         in_txn = (k <= s + t + h);
         strobe = (k > s) && (k <= s + t);
         if (!w && k == s + t + 1) mdl_rdata = rv;
         checkOutput($sformatf("cs_n k=%0d", k),      16'(o_cs_n),      16'(!in_txn));
         checkOutput($sformatf("rd_n k=%0d", k),      16'(o_rd_n),      16'(!(strobe && !w)));
         checkOutput($sformatf("wr_n k=%0d", k),      16'(o_wr_n),      16'(!(strobe && w)));
         checkOutput($sformatf("oe k=%0d", k),        16'(o_oe),        16'(in_txn && w));
         checkOutput($sformatf("addr k=%0d", k),      16'(o_addr),      16'(a));
         if (in_txn) checkOutput($sformatf("dout k=%0d", k), o_dout, d);
         checkOutput($sformatf("rsp_valid k=%0d", k), 16'(o_rsp_valid), 16'(k == s + t + h + 1));
         checkOutput($sformatf("ready k=%0d", k),     16'(o_ready),     16'(k == total));
         checkOutput($sformatf("busy k=%0d", k),      16'(o_busy),      16'(k != total));
         checkOutput($sformatf("rdata k=%0d", k),     o_rdata,          mdl_rdata);
         otg_data_in = strobe ? rv : ~rv;
      end
   endtask

   initial begin
      bit          w, nw, old_int;
      logic [1:0]  a, na;
      logic [15:0] d, nd, rv, nrv, saved_a;
      sel         = 1'b0;
      reset_n     = 1'b0;
      cmd_valid   = 1'b0;
      cmd_write   = 1'b0;
      cmd_addr    = 2'd0;
      cmd_wdata   = 16'd0;
      otg_data_in = 16'd0;
      otg_int     = 1'b0;
      mdl_rdata   = 16'd0;

      repeat (2) @(negedge clk);
      checkIdle("in reset");
      checkOutput("reset rdata", o_rdata, 16'd0);
      checkOutput("reset addr",  16'(o_addr), 16'd0);
      checkOutput("reset dout",  o_dout, 16'd0);
      checkOutput("reset irq",   16'(a_irq), 16'd0);
      reset_n = 1'b1;
      @(negedge clk);
      checkIdle("after reset");

      $display("[TB] directed write / read / write");
      applyStimulus(1'b1, 2'd2, 16'h1234);
      runTxn(1'b1, 2'd2, 16'h1234, 16'h5A5A, 1'b0, 1'b0, 2'd0, 16'd0);
      applyStimulus(1'b0, 2'd0, 16'h0000);
      runTxn(1'b0, 2'd0, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 2'd0, 16'd0);
      applyStimulus(1'b1, 2'd1, 16'hCAFE);
      runTxn(1'b1, 2'd1, 16'hCAFE, 16'h1111, 1'b0, 1'b0, 2'd0, 16'd0);
      checkOutput("rdata kept over write", o_rdata, 16'hBEEF);

      $display("[TB] back-to-back write then read");
      applyStimulus(1'b1, 2'd3, 16'hA5A5);
      runTxn(1'b1, 2'd3, 16'hA5A5, 16'h2222, 1'b1, 1'b0, 2'd2, 16'h0000);
      @(posedge clk);
      runTxn(1'b0, 2'd2, 16'h0000, 16'h7E57, 1'b0, 1'b0, 2'd0, 16'd0);

      $display("[TB] reset in the middle of a write");
      applyStimulus(1'b1, 2'd2, 16'h0F0F);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) cmd_valid = 1'b0;
      end
      checkOutput("wr_n low before reset", 16'(o_wr_n), 16'd0);
      checkOutput("cs_n low before reset", 16'(o_cs_n), 16'd0);
      #1 reset_n = 1'b0;
      #1;
      checkIdle("async reset");
      checkOutput("async reset rdata", o_rdata, 16'd0);
      checkOutput("async reset addr",  16'(o_addr), 16'd0);
      checkOutput("async reset dout",  o_dout, 16'd0);
      mdl_rdata = 16'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkIdle("after mid reset");
      end
      rv = 16'($urandom);
      applyStimulus(1'b0, 2'd3, 16'h0000);
      runTxn(1'b0, 2'd3, 16'h0000, rv, 1'b0, 1'b0, 2'd0, 16'd0);

      $display("[TB] random traffic, default timing");
      for (int i = 0; i < 20; i++) begin
         w  = 1'($urandom_range(0, 1));
         a  = 2'($urandom);
         d  = 16'($urandom);
         rv = 16'($urandom);
         applyStimulus(w, a, d);
         if ($urandom_range(0, 3) == 0) begin
            nw  = 1'($urandom_range(0, 1));
            na  = 2'($urandom);
            nd  = 16'($urandom);
            nrv = 16'($urandom);
            runTxn(w, a, d, rv, 1'b1, nw, na, nd);
            @(posedge clk);
            runTxn(nw, na, nd, nrv, 1'b0, 1'b0, 2'd0, 16'd0);
         end else begin
            runTxn(w, a, d, rv, 1'b0, 1'b0, 2'd0, 16'd0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end

      $display("[TB] minimum timing instance");
      saved_a   = mdl_rdata;
      sel       = 1'b1;
      mdl_rdata = 16'd0;
      @(negedge clk);
      checkIdle("min idle");
      applyStimulus(1'b1, 2'd1, 16'h4321);
      runTxn(1'b1, 2'd1, 16'h4321, 16'h3333, 1'b1, 1'b0, 2'd0, 16'h0000);
      @(posedge clk);
      runTxn(1'b0, 2'd0, 16'h0000, 16'h9876, 1'b0, 1'b0, 2'd0, 16'd0);
      for (int i = 0; i < 8; i++) begin
         w  = 1'($urandom_range(0, 1));
         a  = 2'($urandom);
         d  = 16'($urandom);
         rv = 16'($urandom);
         applyStimulus(w, a, d);
         runTxn(w, a, d, rv, 1'b0, 1'b0, 2'd0, 16'd0);
      end
      sel       = 1'b0;
      mdl_rdata = saved_a;
      @(negedge clk);
      checkOutput("default instance rdata kept", o_rdata, mdl_rdata);

      $display("[TB] interrupt synchroniser");
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         old_int = otg_int;
         #($urandom_range(1, 4)) otg_int = ~otg_int;
         @(posedge clk);
         #1 checkOutput("irq after one edge", 16'(a_irq), 16'(old_int));
         @(posedge clk);
         #1 checkOutput("irq after two edges", 16'(a_irq), 16'(!old_int));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1 checkOutput("irq stable", 16'(a_irq), 16'(!old_int));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/otg_hpi_sequencer.md
# otg_hpi_sequencer

Hardware sequencer for the CY7C67200 (EZ-OTG) Host Port Interface, sitting directly downstream of the SoC's HPI address/data/control PIOs. It replaces software bit-banging of the HPI pins. It accepts one 16-bit read or write command at a time through a valid/ready handshake, then drives the HPI address, chip-select and strobe pins with parameterised setup, strobe, hold and recovery times. Read data comes back as a one-cycle response pulse. The block also synchronises the chip's interrupt line into the clk domain.

## Interface
Parameters:
- SETUP_CYC, 2, cycles with address and cs_n valid before the strobe falls
- STROBE_CYC, 6, cycles rd_n/wr_n are held low
- HOLD_CYC, 2, cycles address, cs_n and write data are held after the strobe rises
- RECOVERY_CYC, 4, cycles cs_n stays high before the next command can be accepted

Any parameter value below 1 is treated as 1.

Ports (reset reset_n, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  sequencer can accept a command this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  2  HPI register select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS)
- cmd_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse: transaction complete
- rsp_rdata  out  16  read data; valid while rsp_valid is high and held until the next read completes
- busy  out  1  high from command acceptance until the end of recovery
- otg_addr  out  2  HPI A[1:0]
- otg_cs_n, otg_rd_n, otg_wr_n  out  1 each  HPI strobes, active-low
- otg_data_out  out  16  data driven to the pad
- otg_data_oe  out  1  tristate enable for otg_data_out
- otg_data_in  in  16  data from the pad
- otg_int  in  1  asynchronous HPI interrupt, active-high
- irq  out  1  synchronised otg_int

## Operation
- All outputs are registered. Reset values:
  - cmd_ready = 1
  - busy = 0
  - otg_cs_n, otg_rd_n, otg_wr_n = 1
  - otg_addr = 0, otg_data_out = 0, otg_data_oe = 0
  - rsp_valid = 0, rsp_rdata = 0, irq = 0
- FSM states: IDLE → SETUP → STROBE → HOLD → RECOVER → IDLE.
- Down-counter width is clog2 of the largest parameter, plus 1. Each phase loads the counter with (N−1) and exits on 0.
- IDLE:
  - cmd_ready = 1.
  - Acceptance occurs on the edge where cmd_valid && cmd_ready.
  - On acceptance, latch cmd_write, cmd_addr and cmd_wdata; drive otg_addr and otg_cs_n = 0; set otg_data_oe = cmd_write and otg_data_out = cmd_wdata; set busy = 1 and cmd_ready = 0.
- SETUP (SETUP_CYC cycles): both strobes high.
- STROBE (STROBE_CYC cycles):
  - Read: otg_rd_n = 0.
  - Write: otg_wr_n = 0.
  - Read data is captured into rsp_rdata on the edge that ends the last STROBE cycle. That is the same edge that raises rd_n, so the sample is taken with rd_n still low.
- HOLD (HOLD_CYC cycles): strobes high; otg_cs_n, otg_addr, otg_data_out and otg_data_oe unchanged.
- RECOVER (RECOVERY_CYC cycles):
  - otg_cs_n = 1, otg_data_oe = 0. otg_addr keeps its last value.
  - rsp_valid = 1 in the first RECOVER cycle only, for both reads and writes.
  - On exit: busy = 0, cmd_ready = 1.
- rd_n and wr_n are never low at the same time. Neither strobe is ever low while cs_n = 1.
- cmd_* inputs are ignored while cmd_ready = 0. A requester holds cmd_valid and keeps its inputs stable until acceptance.
- A write does not change rsp_rdata.
- irq: otg_int passes through a 2-flop synchroniser; no edge detection.

## Timing
- Acceptance edge E0 (defaults in parentheses):
  - SETUP: cycles 1..SETUP_CYC (1–2)
  - STROBE: next STROBE_CYC cycles (3–8)
  - HOLD: next HOLD_CYC cycles (9–10)
  - rsp_valid: cycle S+T+H+1 (11)
  - RECOVER: cycles 11–14
  - cmd_ready high again: cycle S+T+H+R+1 (15)
- Throughput: a new command can be accepted on the edge ending the first cmd_ready cycle. Back-to-back transactions cost S+T+H+R+1 cycles each (15).
- Reset mid-transaction: all outputs return to reset values immediately and asynchronously. The transaction is dropped with no rsp_valid. After release, the FSM is in IDLE.
- irq latency: 2 clk edges after otg_int settles.

## Test plan
- Write: cmd_addr = 2, cmd_wdata = 0x1234 (defaults) → cs_n low cycles 1–10; wr_n low cycles 3–8; oe = 1 and data = 0x1234 cycles 1–10; rsp_valid in cycle 11; cmd_ready in cycle 15.
- Read: cmd_addr = 0, otg_data_in = 0xBEEF during strobe, changed to 0x0000 after rd_n rises → rsp_rdata = 0xBEEF in cycle 11; oe = 0 throughout; rsp_rdata still 0xBEEF after a following write.
- Back-to-back: cmd_valid held high for write then read → second acceptance exactly 15 cycles after the first; no strobe overlap; cs_n high for ≥ 4 cycles between transactions.
- Reset: assert reset_n in cycle 5 of a write → wr_n, cs_n = 1 and oe = 0 immediately; no rsp_valid; after release, cmd_ready = 1 and a new read completes normally.
- Parameters: SETUP_CYC = 0, STROBE_CYC = 1, HOLD_CYC = 0, RECOVERY_CYC = 1 → behaves as 1/1/1/1; rsp_valid in cycle 4; cmd_ready in cycle 5.
- Interrupt: toggle otg_int asynchronously → irq follows after 2 edges; no glitches in irq.
